pipe_csel_adder: RTL
====================

Name: pipe_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit combinational carry-select adder.
- Operand width, group size and groups per pipeline stage are configurable.
- Adds a subtract mode, a signed-overflow flag and valid/ready handshakes on input and output.
- Sits in the datapath as a drop-in streaming arithmetic unit: throughput of one operation per cycle, fixed latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
GROUP, 4, bits per carry-select group.
GPS, 2, groups per pipeline stage; WIDTH/GROUP must be a multiple of GPS.
(derived) NG = WIDTH/GROUP; LAT = NG/GPS, the pipeline depth in cycles.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  input operation valid.
in_ready  out  1  block can accept this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_cin  in  1  carry-in in add mode; borrow-in in subtract mode.
in_sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_sum  out  WIDTH  result.
out_cout  out  1  carry-out in add mode; NOT borrow-out in subtract mode.
out_ovf  out  1  signed (two's complement) overflow.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - On a rising clk edge with rst_n=0: all stage valid bits clear; out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - Any in-flight operations are discarded, never emitted.
  - in_ready is combinational; it reads 1 during reset unless out_valid is held.
- Arithmetic:
  - Effective B: b_eff = in_sub ? ~in_b : in_b.
  - Effective carry-in: c0 = in_cin ^ in_sub.
  - Result: {out_cout, out_sum} = in_a + b_eff + c0, computed modulo 2^(WIDTH+1).
  - Subtract therefore gives a - b - borrow.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Per group:
  - Computes sum and carry for both carry-in=0 and carry-in=1.
  - The selected carry chains group to group; no full ripple across the word.
- Pipeline:
  - Stage k (0..LAT-1) resolves groups k*GPS .. k*GPS+GPS-1 using the carry registered at the end of stage k-1 (c0 for stage 0).
  - Unresolved upper operand slices and the sub flag are delayed alongside.
  - Resolved lower sum slices are carried forward so the final word is aligned.
  - The stage LAT-1 register is the output register.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - An input is accepted when in_valid & in_ready.
  - When advance=0 every stage holds (global stall). When advance=1 every stage shifts, and bubbles propagate as valid=0.
  - Latency: the result for an input accepted at edge N is presented with out_valid=1 after edge N+LAT-1. With LAT=2 this is one cycle after acceptance.
  - Throughput: 1 per cycle when out_ready stays high.
  - out_sum, out_cout and out_ovf are stable while out_valid=1 and out_ready=0.
- Boundaries:
  - Simultaneous accept and emit in the same cycle is legal with no bubble inserted.
  - in_valid=0 inserts a bubble.
  - Results are emitted in order, with no duplication or loss.
  - Carry propagating across all groups (e.g. 0xFFFF+1) must resolve correctly across stage boundaries.

Decomposition:
- Package csel_pkg:
  - Op encoding constants OP_ADD=0, OP_SUB=1.
  - Function lat_f(WIDTH, GROUP, GPS).
  - Elaboration-time parameter legality checks.
- Sub-module csel_group:
  - GROUP-bit, purely combinational.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the group's top bit, used for ovf).
  - Internally computes both carry hypotheses and muxes them.
- Top level instantiates NG csel_group instances plus the stage registers and the handshake logic.

Test Plan:
1. Defaults (LAT=2), add a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0; out_valid rises exactly LAT-1 cycles after the accepting edge.
2. Add a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1; add a=0x1234 b=0x0F0F cin=1 -> 0x2144 cout=0 ovf=0.
3. Sub a=0x0005 b=0x0007 borrow=0 -> 0xFFFE cout=0 ovf=0; sub a=0x8000 b=0x0001 borrow=0 -> 0x7FFF cout=1 ovf=1; sub a=0x0005 b=0x0005 borrow=1 -> 0xFFFF cout=0.
4. Stream 8 back-to-back ops with out_ready=0 for 3 cycles mid-stream -> in_ready=0 in those same cycles, outputs held stable, all 8 results emitted in order with no drop or duplicate.
5. Accept 2 ops, then drive rst_n=0 for one edge -> out_valid=0 and all outputs 0 after that edge; neither op is ever emitted; the next op after reset completes normally.
6. 10k random vectors with random in_valid/out_ready against a behavioural model, run at defaults and at WIDTH=32 GROUP=8 GPS=1 (LAT=4) -> zero mismatches.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package csel_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Pipeline depth: one register stage per GPS carry-select groups.
    function automatic int lat_f(input int width, input int group, input int gps);
        return width / group / gps;
    endfunction

    // Legal only if the word splits evenly into groups and the groups evenly into stages.
    function automatic bit params_ok(input int width, input int group, input int gps);
        return (group > 0) && (gps > 0) && (width >= group * gps) &&
               ((width % group) == 0) && (((width / group) % gps) == 0);
    endfunction

endpackage

// File: rtl/csel_group.sv
// One carry-select group: sums for both carry hypotheses, picked by the real carry-in.
module csel_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [GROUP:0] res0;
    logic [GROUP:0] res1;

    // Evaluate carry-in 0 and carry-in 1 in parallel, then select; c_msb recovers the carry into the top bit.
    always_comb begin
        res0 = {1'b0, a} + {1'b0, b};
        res1 = {1'b0, a} + {1'b0, b} + {{GROUP{1'b0}}, 1'b1};
        if (cin) begin
            sum  = res1[GROUP-1:0];
            cout = res1[GROUP];
        end else begin
            sum  = res0[GROUP-1:0];
            cout = res0[GROUP];
        end
        c_msb = a[GROUP-1] ^ b[GROUP-1] ^ sum[GROUP-1];
    end

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready streaming on both sides.
// Stage k resolves GPS groups using the carry registered by stage k-1; operand bits
// not yet consumed travel alongside, and resolved sum bits accumulate toward the output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The whole pipe moves together: advance = !out_valid | out_ready; in_ready = advance.
// While advance is 0 every stage holds, so out_* stay stable until out_ready is seen.
module pipe_csel_adder
    import csel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LAT = lat_f(WIDTH, GROUP, GPS);
    localparam int SW  = GROUP * GPS;

    if (!params_ok(WIDTH, GROUP, GPS)) begin : g_bad_params
        $error("pipe_csel_adder: WIDTH must be a multiple of GROUP*GPS");
    end

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int LO  = s * SW;     // first bit resolved here
        localparam int HI  = LO + SW;    // bits below HI are resolved after this stage
        localparam int INW = WIDTH - LO; // operand bits still pending on entry

        logic             v_in;
        logic             cin_in;
        logic             sub_in;
        logic [INW-1:0]   a_in;
        logic [INW-1:0]   b_in;
        logic [INW-1:0]   b_eff;
        logic [HI-1:0]    sum_in;
        logic [GPS:0]     carry;
        logic [SW-1:0]    slice;
        logic             v_d, v_q;
        logic             c_d, c_q;
        logic [HI-1:0]    s_d, s_q;

        if (s == 0) begin : g_src
            assign v_in   = in_valid;
            assign sub_in = in_sub;
            assign cin_in = in_cin ^ (in_sub == OP_SUB);
            assign a_in   = in_a;
            assign b_in   = in_b;
            assign sum_in = slice;
        end else begin : g_src
            assign v_in   = g_stage[s-1].v_q;
            assign sub_in = g_stage[s-1].g_up.sub_q;
            assign cin_in = g_stage[s-1].c_q;
            assign a_in   = g_stage[s-1].g_up.a_q;
            assign b_in   = g_stage[s-1].g_up.b_q;
            assign sum_in = {slice, g_stage[s-1].s_q};
        end

        assign b_eff    = (sub_in == OP_SUB) ? ~b_in : b_in;
        assign carry[0] = cin_in;

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            logic msb_carry;

            csel_group #(.GROUP(GROUP)) u_group (
                .a     (a_in[j*GROUP +: GROUP]),
                .b     (b_eff[j*GROUP +: GROUP]),
                .cin   (carry[j]),
                .sum   (slice[j*GROUP +: GROUP]),
                .cout  (carry[j+1]),
                .c_msb (msb_carry)
            );

            // Only the word's top group feeds the overflow flag.
            if (s != LAT - 1 || j != GPS - 1) begin : g_msb_unused
                logic unused_msb;
                assign unused_msb = msb_carry;
            end
        end

        // Valid, carry and resolved sum shift on advance, otherwise hold.
        always_comb begin
            v_d = v_q;
            c_d = c_q;
            s_d = s_q;
            if (advance) begin
                v_d = v_in;
                c_d = carry[GPS];
                s_d = sum_in;
            end
        end

        // Stage register for valid, carry and resolved sum bits.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (s < LAT - 1) begin : g_up
            localparam int UPW = WIDTH - HI;

            logic [UPW-1:0] a_d, a_q;
            logic [UPW-1:0] b_d, b_q;
            logic           sub_d, sub_q;

            // Unresolved operand bits and the op flag ride along to the next stage.
            always_comb begin
                a_d   = a_q;
                b_d   = b_q;
                sub_d = sub_q;
                if (advance) begin
                    a_d   = a_in[INW-1:SW];
                    b_d   = b_in[INW-1:SW];
                    sub_d = sub_in;
                end
            end

            // Pending-operand register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    sub_q <= sub_d;
                end
            end
        end else begin : g_out
            logic ovf_d, ovf_q;

            // Signed overflow: carry into the MSB differs from the carry out of it.
            always_comb begin
                ovf_d = ovf_q;
                if (advance) begin
                    ovf_d = carry[GPS] ^ g_grp[GPS-1].msb_carry;
                end
            end

            // Overflow flag register, part of the output stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[LAT-1].v_q;
    assign out_sum   = g_stage[LAT-1].s_q;
    assign out_cout  = g_stage[LAT-1].c_q;
    assign out_ovf   = g_stage[LAT-1].g_out.ovf_q;

endmodule
